// File: rtl/uart_pkg.sv
// Shared UART encodings: data-width and parity selectors seen by the receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        BITS_5 = 2'b00,
        BITS_6 = 2'b01,
        BITS_7 = 2'b10,
        BITS_8 = 2'b11
    } bits_num_t;

    // 2'b11 is a second encoding of "no parity" kept for host-register compatibility.
    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_ODD      = 2'b01,
        PAR_EVEN     = 2'b10,
        PAR_NONE_ALT = 2'b11
    } parity_t;

    function automatic int unsigned data_width(input logic [1:0] bits_num);
        return 32'd5 + {30'd0, bits_num};
    endfunction

endpackage

// File: rtl/uart_rx_buffer_if.sv
// Bus between the receiver core / host side and the receive buffer.
interface uart_rx_buffer_if #(parameter int DEPTH = 8);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          rx_com;
    logic [8:0]    data_received;
    logic [1:0]    bits_num;
    logic [1:0]    parity;
    logic          rd_en;
    logic          clear_overrun;
    logic [7:0]    rd_data;
    logic          rd_parity_err;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overrun;
    logic          irq;

    modport master (
        output rx_com, data_received, bits_num, parity, rd_en, clear_overrun,
        input  rd_data, rd_parity_err, empty, full, count, overrun, irq
    );

    modport slave (
        input  rx_com, data_received, bits_num, parity, rd_en, clear_overrun,
        output rd_data, rd_parity_err, empty, full, count, overrun, irq
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Generic first-word-fall-through FIFO with a separate occupancy counter.
module uart_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_write;
    logic             do_read;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_COUNT);
    assign do_read  = rd_en & ~empty;
    // A full FIFO still accepts a write when the head is popped in the same cycle.
    assign do_write = wr_en & (~full | rd_en);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (do_read)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_write, do_read})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is never cleared; the empty gate below hides stale contents.
    always_ff @(posedge clk) begin
        if (reset && do_write) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];
    assign count   = count_q;

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive buffer: parity check of completed frames, FIFO storage, sticky overrun and level irq.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int IRQ_LEVEL = 4
) (
    input logic               clk,
    input logic               reset,
    uart_rx_buffer_if.slave   bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] IRQ_COUNT = CW'(IRQ_LEVEL);

    logic [7:0]    frame_data;
    logic          parity_bit;
    logic          parity_err;
    logic [8:0]    head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          drop;
    logic          overrun_q;
    logic          irq_q;

    // Split the frame at the configured width; the bit just above the data is the parity bit.
    always_comb begin
        frame_data = '0;
        parity_bit = 1'b0;
        case (bits_num_t'(bus.bits_num))
            BITS_5: begin
                frame_data = {3'b000, bus.data_received[4:0]};
                parity_bit = bus.data_received[5];
            end
            BITS_6: begin
                frame_data = {2'b00, bus.data_received[5:0]};
                parity_bit = bus.data_received[6];
            end
            BITS_7: begin
                frame_data = {1'b0, bus.data_received[6:0]};
                parity_bit = bus.data_received[7];
            end
            default: begin
                frame_data = bus.data_received[7:0];
                parity_bit = bus.data_received[8];
            end
        endcase

        parity_err = 1'b0;
        case (parity_t'(bus.parity))
            PAR_ODD:  parity_err = ~((^frame_data) ^ parity_bit);
            PAR_EVEN: parity_err = (^frame_data) ^ parity_bit;
            default:  parity_err = 1'b0;
        endcase
    end

    uart_sync_fifo #(
        .WIDTH (9),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (bus.rx_com),
        .wr_data ({parity_err, frame_data}),
        .rd_en   (bus.rd_en),
        .rd_data (head),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign drop = bus.rx_com & fifo_full & ~bus.rd_en;

    // Overrun set takes priority over a same-cycle clear; irq lags its sources by one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overrun_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            if (drop)                   overrun_q <= 1'b1;
            else if (bus.clear_overrun) overrun_q <= 1'b0;
            irq_q <= (fifo_count >= IRQ_COUNT) | overrun_q;
        end
    end

    assign bus.rd_data       = head[7:0];
    assign bus.rd_parity_err = head[8];
    assign bus.empty         = fifo_empty;
    assign bus.full          = fifo_full;
    assign bus.count         = fifo_count;
    assign bus.overrun       = overrun_q;
    assign bus.irq           = irq_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Bench for uart_rx_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_uart_rx_buffer;

    localparam int DEPTH     = 8;
    localparam int IRQ_LEVEL = 4;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    logic [8:0] exp_q [$];
    logic       exp_overrun;
    logic       exp_irq;

    uart_rx_buffer_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_buffer #(
        .DEPTH     (DEPTH),
        .IRQ_LEVEL (IRQ_LEVEL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference entry from the parity rules: count ones in data plus parity bit.
    function automatic logic [8:0] make_entry(input logic [8:0] frame, input logic [1:0] bn, input logic [1:0] par);
        int n;
        int ones;
        logic [7:0] d;
        logic p;
        logic e;
        n    = 5 + int'(bn);
        d    = 8'(frame & ((9'd1 << n) - 9'd1));
        p    = frame[n];
        ones = $countones(d) + int'(p);
        if (par == 2'b01)      e = (ones % 2 == 0);
        else if (par == 2'b10) e = (ones % 2 == 1);
        else                   e = 1'b0;
        return {e, d};
    endfunction

    task automatic model_edge();
        int  size;
        logic irq_next;
        logic push;
        logic pop;
        logic dropped;
        if (!reset) begin
            exp_q.delete();
            exp_overrun = 1'b0;
            exp_irq     = 1'b0;
        end else begin
            size     = exp_q.size();
            irq_next = (size >= IRQ_LEVEL) || exp_overrun;
            pop      = bus.rd_en && size > 0;
            push     = bus.rx_com && (size < DEPTH || bus.rd_en);
            dropped  = bus.rx_com && size == DEPTH && !bus.rd_en;
            if (pop)  void'(exp_q.pop_front());
            if (push) exp_q.push_back(make_entry(bus.data_received, bus.bits_num, bus.parity));
            if (dropped)                exp_overrun = 1'b1;
            else if (bus.clear_overrun) exp_overrun = 1'b0;
            exp_irq = irq_next;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic rx, input logic [8:0] frame, input logic [1:0] bn,
                         input logic [1:0] par, input logic rd, input logic clr);
        bus.rx_com        = rx;
        bus.data_received = frame;
        bus.bits_num      = bn;
        bus.parity        = par;
        bus.rd_en         = rd;
        bus.clear_overrun = clr;
    endtask

    task automatic idle();
        drive(1'b0, 9'h000, 2'b11, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (bus.empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_empty got=%b exp=1", bus.empty); end
        tests_run++; if (bus.full !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_full got=%b exp=0", bus.full); end
        tests_run++; if (bus.count !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_count got=%0d exp=0", bus.count); end
        tests_run++; if (bus.overrun !== 1'b0 || bus.irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_flags got ovr=%b irq=%b exp 0/0", bus.overrun, bus.irq); end
        tests_run++; if (bus.rd_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_rd_data got=%h exp=00", bus.rd_data); end
    endtask

    task automatic test_parity_modes();
        logic [8:0] frames [4];
        logic [1:0] bns    [4];
        logic [1:0] pars   [4];
        logic [7:0] exp_d  [4];
        logic       exp_e  [4];
        frames = '{9'h0A5, 9'h0D5, 9'h03F, 9'h001};
        bns    = '{2'b11,  2'b10,  2'b00,  2'b01};
        pars   = '{2'b10,  2'b01,  2'b00,  2'b10};
        exp_d  = '{8'hA5,  8'h55,  8'h1F,  8'h01};
        exp_e  = '{1'b0,   1'b0,   1'b0,   1'b1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, frames[i], bns[i], pars[i], 1'b0, 1'b0);
            tick();
            idle();
            tests_run++; if (bus.rd_data !== exp_d[i]) begin tests_failed++; $display("[TB] FAIL parity_data[%0d] got=%h exp=%h", i, bus.rd_data, exp_d[i]); end
            tests_run++; if (bus.rd_parity_err !== exp_e[i]) begin tests_failed++; $display("[TB] FAIL parity_err[%0d] got=%b exp=%b", i, bus.rd_parity_err, exp_e[i]); end
            tests_run++; if (bus.count !== 4'd1 || bus.empty !== 1'b0) begin tests_failed++; $display("[TB] FAIL parity_occupancy[%0d] got count=%0d empty=%b exp 1/0", i, bus.count, bus.empty); end
            bus.rd_en = 1'b1;
            tick();
            idle();
        end
    endtask

    task automatic test_overrun();
        logic [7:0] written [DEPTH];
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            written[i] = 8'($urandom);
            drive(1'b1, {1'b0, written[i]}, 2'b11, 2'b00, 1'b0, 1'b0);
            tick();
        end
        idle();
        tests_run++; if (bus.full !== 1'b1 || bus.count !== 4'd8) begin tests_failed++; $display("[TB] FAIL fill_full got full=%b count=%0d exp 1/8", bus.full, bus.count); end
        tests_run++; if (bus.irq !== 1'b1) begin tests_failed++; $display("[TB] FAIL fill_irq got=%b exp=1", bus.irq); end
        drive(1'b1, 9'h0EE, 2'b11, 2'b00, 1'b0, 1'b0);
        tick();
        idle();
        tests_run++; if (bus.overrun !== 1'b1 || bus.count !== 4'd8) begin tests_failed++; $display("[TB] FAIL drop_overrun got ovr=%b count=%0d exp 1/8", bus.overrun, bus.count); end
        for (int i = 0; i < DEPTH; i++) begin
            tests_run++; if (bus.rd_data !== written[i]) begin tests_failed++; $display("[TB] FAIL drain_order[%0d] got=%h exp=%h", i, bus.rd_data, written[i]); end
            bus.rd_en = 1'b1;
            tick();
        end
        idle();
        tests_run++; if (bus.empty !== 1'b1 || bus.overrun !== 1'b1) begin tests_failed++; $display("[TB] FAIL drained_state got empty=%b ovr=%b exp 1/1", bus.empty, bus.overrun); end
        bus.clear_overrun = 1'b1;
        tick();
        idle();
        tests_run++; if (bus.overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL clear_overrun got=%b exp=0", bus.overrun); end
        tick();
        tests_run++; if (bus.irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL irq_after_clear got=%b exp=0", bus.irq); end
    endtask

    task automatic test_full_simultaneous();
        logic [7:0] last_seen;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 9'(i), 2'b11, 2'b00, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 9'h0C3, 2'b11, 2'b00, 1'b1, 1'b0);
        tick();
        idle();
        tests_run++; if (bus.count !== 4'd8 || bus.overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_rw got count=%0d ovr=%b exp 8/0", bus.count, bus.overrun); end
        tests_run++; if (bus.rd_data !== 8'h01) begin tests_failed++; $display("[TB] FAIL full_rw_head got=%h exp=01", bus.rd_data); end
        last_seen = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            last_seen = bus.rd_data;
            bus.rd_en = 1'b1;
            tick();
        end
        idle();
        tests_run++; if (last_seen !== 8'hC3) begin tests_failed++; $display("[TB] FAIL full_rw_last got=%h exp=c3", last_seen); end
    endtask

    task automatic test_empty_simultaneous();
        do_reset();
        drive(1'b1, 9'h05A, 2'b11, 2'b00, 1'b1, 1'b0);
        tick();
        idle();
        tests_run++; if (bus.count !== 4'd1 || bus.rd_data !== 8'h5A) begin tests_failed++; $display("[TB] FAIL empty_rw got count=%0d data=%h exp 1/5a", bus.count, bus.rd_data); end
        bus.rd_en = 1'b1;
        tick();
        tick();
        idle();
        tests_run++; if (bus.count !== 4'd0 || bus.rd_data !== 8'h00 || bus.empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL empty_read got count=%0d data=%h empty=%b exp 0/00/1", bus.count, bus.rd_data, bus.empty); end
    endtask

    task automatic test_reset_midop();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 9'($urandom), 2'b11, 2'b10, 1'b0, 1'b0);
            tick();
        end
        tests_run++; if (bus.count !== 4'd5) begin tests_failed++; $display("[TB] FAIL midop_prefill got=%0d exp=5", bus.count); end
        drive(1'b1, 9'h111, 2'b11, 2'b00, 1'b1, 1'b0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        idle();
        tests_run++; if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.irq !== 1'b0 || bus.overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL midop_reset got count=%0d empty=%b irq=%b ovr=%b exp 0/1/0/0", bus.count, bus.empty, bus.irq, bus.overrun); end
    endtask

    task automatic test_random_traffic();
        logic [7:0] e_data;
        logic       e_err;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            drive($urandom_range(0, 99) < 55, 9'($urandom), 2'($urandom), 2'($urandom),
                  $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 8);
            reset = ($urandom_range(0, 199) != 0);
            tick();
            e_data = (exp_q.size() > 0) ? exp_q[0][7:0] : 8'h00;
            e_err  = (exp_q.size() > 0) ? exp_q[0][8]   : 1'b0;
            tests_run++; if (bus.rd_data !== e_data || bus.rd_parity_err !== e_err) begin tests_failed++; $display("[TB] FAIL rand_head cyc=%0d got=%b/%h exp=%b/%h", cyc, bus.rd_parity_err, bus.rd_data, e_err, e_data); end
            tests_run++; if (bus.count !== 4'(exp_q.size()) || bus.empty !== (exp_q.size() == 0) || bus.full !== (exp_q.size() == DEPTH)) begin tests_failed++; $display("[TB] FAIL rand_level cyc=%0d got count=%0d empty=%b full=%b exp count=%0d", cyc, bus.count, bus.empty, bus.full, exp_q.size()); end
            tests_run++; if (bus.overrun !== exp_overrun || bus.irq !== exp_irq) begin tests_failed++; $display("[TB] FAIL rand_flags cyc=%0d got ovr=%b irq=%b exp ovr=%b irq=%b", cyc, bus.overrun, bus.irq, exp_overrun, exp_irq); end
        end
        reset = 1'b1;
        idle();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_overrun  = 1'b0;
        exp_irq      = 1'b0;
        reset        = 1'b0;
        idle();
        test_reset();
        test_parity_modes();
        test_overrun();
        test_full_simultaneous();
        test_empty_simultaneous();
        test_reset_midop();
        test_random_traffic();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
